// File: rtl/sp_ram_req_ctrl.sv
// Single-port RAM behind a valid/ready request channel with an in-order buffered response path.
// Define SP_RAM_PARITY_EN to add per-byte even parity and the inj_par_err test input.
module sp_ram_req_ctrl #(
    parameter int ADDRWIDTH  = 4,
    parameter int DATAWIDTH  = 8,
    parameter int SIZE       = 16,
    parameter int RESP_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDRWIDTH-1:0]   req_addr,
    input  logic [DATAWIDTH-1:0]   req_wdata,
    input  logic [DATAWIDTH/8-1:0] req_be,
`ifdef SP_RAM_PARITY_EN
    input  logic                   inj_par_err,
`endif
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATAWIDTH-1:0]   resp_rdata,
    output logic                   resp_err,
    output logic                   init_done
);
    localparam int NB = DATAWIDTH / 8;
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(SIZE - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t state, state_nxt;

    logic [DATAWIDTH-1:0] mem [SIZE];
    logic [ADDRWIDTH-1:0] sweep_cnt;
    logic                 inflight, pend_err;
    logic [DATAWIDTH-1:0] pend_rdata;
    logic                 push_err;

    logic [DATAWIDTH-1:0] fifo_d [RESP_DEPTH];
    logic                 fifo_e [RESP_DEPTH];
    logic [PW-1:0]        head, tail;
    logic [CW-1:0]        count;
    logic [DATAWIDTH-1:0] last_rdata;
    logic                 last_err;

    logic accept, in_range, push, pop;

    assign in_range = {1'b0, req_addr} < (ADDRWIDTH+1)'(SIZE);
    assign accept   = req_valid && req_ready;
    assign push     = inflight;
    assign pop      = resp_valid && resp_ready;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && sweep_cnt == LAST_ADDR) state_nxt = S_RUN;
    end

    // Occupancy counts the entry still in flight so the buffer can never overflow.
    always_comb begin
        init_done = (state == S_RUN);
        req_ready = (state == S_RUN) &&
                    (((CW+1)'(count) + (CW+1)'(inflight)) < (CW+1)'(RESP_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                sweep_cnt <= '0;
        else if (state == S_INIT)  sweep_cnt <= sweep_cnt + 1'b1;
    end

    // ---------------- array (no reset; cleared by the sweep) ----------------
`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [SIZE];
    logic [NB-1:0] pend_par;
    logic          pend_chk;
`endif

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[sweep_cnt] <= '0;
`ifdef SP_RAM_PARITY_EN
            par_mem[sweep_cnt] <= '0;
`endif
        end else if (accept && req_we && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
`ifdef SP_RAM_PARITY_EN
                    par_mem[req_addr][b] <= (^req_wdata[b*8 +: 8]) ^ inj_par_err;
`endif
                end
            end
        end
    end

    // ---------------- access stage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= 1'b0;
            pend_err   <= 1'b0;
            pend_rdata <= '0;
`ifdef SP_RAM_PARITY_EN
            pend_par   <= '0;
            pend_chk   <= 1'b0;
`endif
        end else begin
            inflight <= accept;
            if (accept) begin
                pend_err   <= !in_range;
                pend_rdata <= (!req_we && in_range) ? mem[req_addr] : '0;
`ifdef SP_RAM_PARITY_EN
                pend_par   <= in_range ? par_mem[req_addr] : '0;
                pend_chk   <= !req_we && in_range;
`endif
            end
        end
    end

    always_comb begin
        push_err = pend_err;
`ifdef SP_RAM_PARITY_EN
        for (int b = 0; b < NB; b++)
            if (pend_chk && ((^pend_rdata[b*8 +: 8]) != pend_par[b])) push_err = 1'b1;
`endif
    end

    // ---------------- response FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d[tail] <= pend_rdata;
            fifo_e[tail] <= push_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            last_rdata <= '0;
            last_err   <= 1'b0;
        end else begin
            if (push) tail <= wrap_inc(tail);
            if (pop) begin
                head       <= wrap_inc(head);
                last_rdata <= fifo_d[head];
                last_err   <= fifo_e[head];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs keep showing the last popped entry while the buffer is empty.
    assign resp_valid = (count != '0);
    assign resp_rdata = resp_valid ? fifo_d[head] : last_rdata;
    assign resp_err   = resp_valid ? fifo_e[head] : last_err;

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Randomized and directed checks of sp_ram_req_ctrl against a queue/array reference model.
module tb_sp_ram_req_ctrl;
    localparam int AW = 4, DW = 16, SZ = 12, RD = 3, NB = DW / 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NB-1:0] req_be = '0;
    logic          req_ready, resp_valid, resp_err, init_done;
    logic [DW-1:0] resp_rdata;
`ifdef SP_RAM_PARITY_EN
    logic          inj_par_err = 1'b0;
`endif

    sp_ram_req_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .SIZE(SZ), .RESP_DEPTH(RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef SP_RAM_PARITY_EN
        .inj_par_err(inj_par_err),
`endif
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {logic [DW-1:0] d; logic e; int acc;} ent_t;
    ent_t          q[$];
    logic [DW-1:0] mem_m [SZ];
    logic [DW-1:0] last_d;
    logic          last_e;
    int            cyc = 0, edges = 0, checks = 0, errors = 0;
    bit            run_m = 0, last_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < SZ; i++) mem_m[i] = '0;
        last_d = '0; last_e = 1'b0; edges = 0; run_m = 0;
    endtask

    // One clock: check at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit exp_ready, exp_valid, acc, pop;
        ent_t e;
        @(negedge clk);
        exp_ready = rst_n && run_m && (q.size() < RD);
        exp_valid = (q.size() > 0) && (q[0].acc < cyc);
        chk("req_ready", req_ready, exp_ready);
        chk("init_done", init_done, run_m);
        chk("resp_valid", resp_valid, exp_valid);
        chk("resp_rdata", resp_rdata, exp_valid ? q[0].d : last_d);
        chk("resp_err", resp_err, exp_valid ? q[0].e : last_e);
        acc = req_valid && exp_ready;
        pop = exp_valid && resp_ready;
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (rst_n) begin
            if (!run_m) begin edges++; if (edges == SZ) run_m = 1; end
            if (pop) begin last_d = q[0].d; last_e = q[0].e; void'(q.pop_front()); end
            if (acc) begin
                e.acc = cyc;
                e.e   = (int'(req_addr) >= SZ);
                e.d   = '0;
                if (!e.e && req_we) begin
                    for (int b = 0; b < NB; b++)
                        if (req_be[b]) mem_m[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end else if (!e.e) e.d = mem_m[req_addr];
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic send(input bit we, input int addr, input logic [DW-1:0] wd, input logic [NB-1:0] be);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = AW'(addr); req_wdata = wd; req_be = be;
        do begin cycle(); n++; end while (!last_acc && n < 20);
        if (!last_acc) chk("send_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        resp_ready = 1'b1; req_valid = 1'b0;
        repeat (6) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_init_done"}, init_done, 0);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst");
        rst_n = 1'b1;
        // Requests during the sweep must be ignored.
        repeat (SZ + 3) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = AW'($urandom);
            req_wdata = DW'($urandom); req_be = NB'($urandom);
            cycle();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        for (int a = 0; a < 16; a++) send(0, a, '0, '0);
        drain();

        send(1, 5, 16'hA5A5, 2'b11);
        send(0, 5, '0, '0);
        send(1, 2, 16'h1234, 2'b11);
        send(1, 2, 16'hFFFF, 2'b01);
        send(0, 2, '0, '0);
        send(0, 13, '0, '0);
        send(1, 14, 16'hBEEF, 2'b11);
        send(1, 7, 16'h5555, 2'b00);
        send(0, 7, '0, '0);
        drain();

        // Backpressure: five reads offered, only RD accepted.
        resp_ready = 1'b0; n = 0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 5; i++) begin req_addr = AW'(i); cycle(); n += int'(last_acc); end
        chk("bp_accepts", n, RD);
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && n < 5; i++) begin req_addr = AW'(n); cycle(); n += int'(last_acc); end
        chk("bp_total", n, 5);
        drain();

        n = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin req_addr = AW'(i); cycle(); n += int'(last_acc); end
        chk("b2b_accepts", n, 8);
        drain();

        repeat (400) begin
            req_valid = ($urandom_range(0, 3) != 0); req_we = 1'($urandom);
            req_addr = AW'($urandom); req_wdata = DW'($urandom); req_be = NB'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Reset in the middle of a burst.
        send(1, 3, 16'h0F0F, 2'b11);
        resp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
        repeat (2) cycle();
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        cycle();
        rst_n = 1'b1;
        repeat (SZ + 1) cycle();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        send(0, 3, '0, '0);
        send(0, 5, '0, '0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
